// File: rtl/masked_multilevel_barrier.sv
// Masked multi-level arrival barrier with flush, sticky overflow and release generation count.
// Optional stall watchdog compiled in with `define BARRIER_WATCHDOG_EN.
module masked_multilevel_barrier #(
    parameter int NUM_LEVELS     = 2,
    parameter int COUNTER_BITS   = 4,
    parameter int GEN_BITS       = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_LEVELS-1:0] in_wait,
    input  logic [NUM_LEVELS-1:0] in_mask,
    input  logic                  in_flush,
    output logic                  out_release,
    output logic [NUM_LEVELS-1:0] out_pending,
    output logic [NUM_LEVELS-1:0] out_overflow,
    output logic [GEN_BITS-1:0]   out_generation,
    output logic                  out_stall
);

    localparam logic [COUNTER_BITS-1:0] CNT_MAX = '1;

    logic [COUNTER_BITS-1:0] r_cnt [NUM_LEVELS];
    logic [COUNTER_BITS-1:0] w_cnt_nxt [NUM_LEVELS];
    logic [NUM_LEVELS-1:0]   r_ovf;
    logic [NUM_LEVELS-1:0]   w_ovf_set;
    logic [NUM_LEVELS-1:0]   w_pend;
    logic [GEN_BITS-1:0]     r_gen;
    logic                    w_ready;
    logic                    w_release;

    always_comb begin
        for (int i = 0; i < NUM_LEVELS; i++) begin
            w_pend[i] = (r_cnt[i] != '0);
        end
        w_ready   = (|in_mask) & (&(w_pend | ~in_mask));
        w_release = w_ready & ~in_flush & ~reset;
    end

    // Masked levels freeze; a wait and a release on the same level cancel out.
    always_comb begin
        for (int i = 0; i < NUM_LEVELS; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            w_ovf_set[i] = 1'b0;
            if (in_flush) begin
                w_cnt_nxt[i] = '0;
            end else if (in_mask[i]) begin
                if (in_wait[i] && !w_release) begin
                    if (r_cnt[i] == CNT_MAX) begin
                        w_ovf_set[i] = 1'b1;
                    end else begin
                        w_cnt_nxt[i] = r_cnt[i] + COUNTER_BITS'(1);
                    end
                end else if (!in_wait[i] && w_release) begin
                    w_cnt_nxt[i] = r_cnt[i] - COUNTER_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_LEVELS; i++) begin
                r_cnt[i] <= '0;
            end
            r_ovf <= '0;
            r_gen <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_ovf <= r_ovf | w_ovf_set;
            if (w_release) begin
                r_gen <= r_gen + GEN_BITS'(1);
            end
        end
    end

`ifdef BARRIER_WATCHDOG_EN
    localparam int STALL_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(TIMEOUT_CYCLES);

    logic [STALL_W-1:0] r_stall;
    logic               w_blocked;

    assign w_blocked = (|(w_pend & in_mask)) & ~w_release & ~in_flush;

    always_ff @(posedge clk) begin
        if (reset || !w_blocked) begin
            r_stall <= '0;
        end else if (r_stall != STALL_MAX) begin
            r_stall <= r_stall + STALL_W'(1);
        end
    end

    assign out_stall = (r_stall == STALL_MAX) & ~reset;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
    assign out_stall        = 1'b0;
`endif

    assign out_release    = w_release;
    assign out_pending    = w_pend;
    assign out_overflow   = r_ovf;
    assign out_generation = r_gen;

endmodule

// File: tb/tb_masked_multilevel_barrier.sv
// Directed self-checking bench for masked_multilevel_barrier (3 levels, 2-bit counters, 2-bit generation).
// Watchdog scenario is exercised when BARRIER_WATCHDOG_EN is defined.
module tb_masked_multilevel_barrier;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] in_wait;
    logic [2:0] in_mask;
    logic       in_flush;
    logic       out_release;
    logic [2:0] out_pending;
    logic [2:0] out_overflow;
    logic [1:0] out_generation;
    logic       out_stall;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    masked_multilevel_barrier #(
        .NUM_LEVELS    (3),
        .COUNTER_BITS  (2),
        .GEN_BITS      (2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .in_wait       (in_wait),
        .in_mask       (in_mask),
        .in_flush      (in_flush),
        .out_release   (out_release),
        .out_pending   (out_pending),
        .out_overflow  (out_overflow),
        .out_generation(out_generation),
        .out_stall     (out_stall)
    );

    // Inputs change just after the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc(input logic [2:0] w, input logic [2:0] m, input logic f);
        @(negedge clk);
        in_wait  = w;
        in_mask  = m;
        in_flush = f;
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        cyc(3'b111, 3'b111, 1'b0);
        checks++;
        if (out_release !== 1'b0) begin
            errors++;
            $display("FAIL reset_rel: got=%b exp=0", out_release);
        end
        checks++;
        if (out_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got=%b exp=0", out_stall);
        end
        @(negedge clk);
        reset = 1'b0;
        in_wait = 3'b000;
        #1;
        checks++;
        if (out_pending !== 3'b000) begin
            errors++;
            $display("FAIL reset_pend: got=%b exp=000", out_pending);
        end
        checks++;
        if (out_overflow !== 3'b000) begin
            errors++;
            $display("FAIL reset_ovf: got=%b exp=000", out_overflow);
        end
        checks++;
        if (out_generation !== 2'd0) begin
            errors++;
            $display("FAIL reset_gen: got=%0d exp=0", out_generation);
        end
        checks++;
        if (out_release !== 1'b0) begin
            errors++;
            $display("FAIL reset_after_rel: got=%b exp=0", out_release);
        end
    endtask

    task automatic test_arrival;
        logic [2:0] w;
        for (int t = 0; t <= 7; t++) begin
            w = (t == 0) ? 3'b001 : (t == 2) ? 3'b010 : (t == 5) ? 3'b100 : 3'b000;
            cyc(w, 3'b111, 1'b0);
            checks++;
            if (out_release !== (t == 6)) begin
                errors++;
                $display("FAIL arrival_rel_t%0d: got=%b exp=%b", t, out_release, (t == 6));
            end
            if (t == 6) begin
                checks++;
                if (out_generation !== 2'd0) begin
                    errors++;
                    $display("FAIL arrival_gen_t6: got=%0d exp=0", out_generation);
                end
            end
            if (t == 7) begin
                checks++;
                if (out_generation !== 2'd1) begin
                    errors++;
                    $display("FAIL arrival_gen_t7: got=%0d exp=1", out_generation);
                end
                checks++;
                if (out_pending !== 3'b000) begin
                    errors++;
                    $display("FAIL arrival_pend_t7: got=%b exp=000", out_pending);
                end
            end
        end
    endtask

    task automatic test_mask;
        cyc(3'b101, 3'b101, 1'b0);
        checks++;
        if (out_release !== 1'b0) begin
            errors++;
            $display("FAIL mask_rel_a: got=%b exp=0", out_release);
        end
        cyc(3'b000, 3'b101, 1'b0);
        checks++;
        if (out_release !== 1'b1) begin
            errors++;
            $display("FAIL mask_rel_b: got=%b exp=1", out_release);
        end
        checks++;
        if (out_pending !== 3'b101) begin
            errors++;
            $display("FAIL mask_pend_b: got=%b exp=101", out_pending);
        end
        cyc(3'b000, 3'b101, 1'b0);
        checks++;
        if (out_pending !== 3'b000) begin
            errors++;
            $display("FAIL mask_pend_c: got=%b exp=000", out_pending);
        end
        checks++;
        if (out_generation !== 2'd2) begin
            errors++;
            $display("FAIL mask_gen_c: got=%0d exp=2", out_generation);
        end
        cyc(3'b111, 3'b111, 1'b0);
        cyc(3'b111, 3'b000, 1'b0);
        checks++;
        if (out_release !== 1'b0) begin
            errors++;
            $display("FAIL mask_none_rel: got=%b exp=0", out_release);
        end
        cyc(3'b000, 3'b000, 1'b0);
        checks++;
        if (out_pending !== 3'b111 || out_release !== 1'b0) begin
            errors++;
            $display("FAIL mask_none_hold: pend=%b rel=%b exp pend=111 rel=0", out_pending, out_release);
        end
        cyc(3'b000, 3'b111, 1'b0);
        checks++;
        if (out_release !== 1'b1) begin
            errors++;
            $display("FAIL mask_reenable_rel: got=%b exp=1", out_release);
        end
        cyc(3'b000, 3'b111, 1'b0);
        checks++;
        if (out_pending !== 3'b000 || out_generation !== 2'd3) begin
            errors++;
            $display("FAIL mask_reenable_after: pend=%b gen=%0d exp pend=000 gen=3", out_pending, out_generation);
        end
    endtask

    task automatic test_overflow_back_to_back;
        for (int k = 0; k < 4; k++) begin
            cyc(3'b001, 3'b011, 1'b0);
            checks++;
            if (out_overflow !== 3'b000 || out_release !== 1'b0) begin
                errors++;
                $display("FAIL ovf_fill_%0d: ovf=%b rel=%b exp ovf=000 rel=0", k, out_overflow, out_release);
            end
        end
        cyc(3'b010, 3'b011, 1'b0);
        checks++;
        if (out_overflow !== 3'b001 || out_pending !== 3'b001 || out_release !== 1'b0) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b pend=%b rel=%b exp 001 001 0", out_overflow, out_pending, out_release);
        end
        for (int k = 0; k < 3; k++) begin
            cyc((k < 2) ? 3'b010 : 3'b000, 3'b011, 1'b0);
            checks++;
            if (out_release !== 1'b1) begin
                errors++;
                $display("FAIL b2b_rel_%0d: got=%b exp=1", k, out_release);
            end
        end
        cyc(3'b000, 3'b011, 1'b0);
        checks++;
        if (out_release !== 1'b0 || out_pending !== 3'b000) begin
            errors++;
            $display("FAIL b2b_end: rel=%b pend=%b exp rel=0 pend=000", out_release, out_pending);
        end
        checks++;
        if (out_overflow !== 3'b001 || out_generation !== 2'd2) begin
            errors++;
            $display("FAIL b2b_sticky: ovf=%b gen=%0d exp ovf=001 gen=2", out_overflow, out_generation);
        end
    endtask

    task automatic test_flush;
        cyc(3'b001, 3'b011, 1'b0);
        cyc(3'b011, 3'b011, 1'b0);
        cyc(3'b011, 3'b011, 1'b1);
        checks++;
        if (out_release !== 1'b0 || out_pending !== 3'b011) begin
            errors++;
            $display("FAIL flush_cycle: rel=%b pend=%b exp rel=0 pend=011", out_release, out_pending);
        end
        cyc(3'b000, 3'b011, 1'b0);
        checks++;
        if (out_pending !== 3'b000 || out_release !== 1'b0) begin
            errors++;
            $display("FAIL flush_after: pend=%b rel=%b exp pend=000 rel=0", out_pending, out_release);
        end
        checks++;
        if (out_generation !== 2'd2 || out_overflow !== 3'b001) begin
            errors++;
            $display("FAIL flush_keep: gen=%0d ovf=%b exp gen=2 ovf=001", out_generation, out_overflow);
        end
    endtask

    task automatic test_reset_gen_wrap;
        logic [1:0] exp_gen [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        cyc(3'b011, 3'b111, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        in_wait = 3'b000;
        in_mask = 3'b011;
        #1;
        checks++;
        if (out_release !== 1'b0 || out_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_loaded: rel=%b stall=%b exp 0 0", out_release, out_stall);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_release !== 1'b0 || out_pending !== 3'b000 ||
            out_overflow !== 3'b000 || out_generation !== 2'd0) begin
            errors++;
            $display("FAIL rst_clear: rel=%b pend=%b ovf=%b gen=%0d exp 0 000 000 0",
                     out_release, out_pending, out_overflow, out_generation);
        end
        cyc(3'b011, 3'b011, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc((i < 4) ? 3'b011 : 3'b000, 3'b011, 1'b0);
            checks++;
            if (out_release !== 1'b1 || out_generation !== exp_gen[i]) begin
                errors++;
                $display("FAIL gen_wrap_%0d: rel=%b gen=%0d exp rel=1 gen=%0d",
                         i, out_release, out_generation, exp_gen[i]);
            end
        end
        cyc(3'b000, 3'b011, 1'b0);
        checks++;
        if (out_release !== 1'b0 || out_generation !== 2'd1 || out_pending !== 3'b000) begin
            errors++;
            $display("FAIL gen_wrap_end: rel=%b gen=%0d pend=%b exp 0 1 000",
                     out_release, out_generation, out_pending);
        end
    endtask

    task automatic test_sat_cancel;
        for (int k = 0; k < 3; k++) cyc(3'b011, 3'b111, 1'b0);
        cyc(3'b100, 3'b111, 1'b0);
        checks++;
        if (out_release !== 1'b0) begin
            errors++;
            $display("FAIL sat_pre_rel: got=%b exp=0", out_release);
        end
        cyc(3'b010, 3'b111, 1'b0);
        checks++;
        if (out_release !== 1'b1) begin
            errors++;
            $display("FAIL sat_cancel_rel: got=%b exp=1", out_release);
        end
        cyc(3'b000, 3'b111, 1'b0);
        checks++;
        if (out_overflow !== 3'b000 || out_pending !== 3'b011) begin
            errors++;
            $display("FAIL sat_cancel_ovf: ovf=%b pend=%b exp ovf=000 pend=011", out_overflow, out_pending);
        end
        cyc(3'b000, 3'b111, 1'b1);
        cyc(3'b000, 3'b111, 1'b0);
    endtask

    task automatic test_watchdog;
`ifdef BARRIER_WATCHDOG_EN
        cyc(3'b001, 3'b011, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            cyc(3'b000, 3'b011, 1'b0);
            checks++;
            if (out_stall !== 1'b0) begin
                errors++;
                $display("FAIL wd_early_%0d: stall=%b exp=0", k, out_stall);
            end
        end
        cyc(3'b010, 3'b011, 1'b0);
        checks++;
        if (out_stall !== 1'b1 || out_release !== 1'b0) begin
            errors++;
            $display("FAIL wd_rise: stall=%b rel=%b exp stall=1 rel=0", out_stall, out_release);
        end
        cyc(3'b000, 3'b011, 1'b0);
        checks++;
        if (out_release !== 1'b1 || out_stall !== 1'b1) begin
            errors++;
            $display("FAIL wd_release: rel=%b stall=%b exp 1 1", out_release, out_stall);
        end
        cyc(3'b000, 3'b011, 1'b0);
        checks++;
        if (out_stall !== 1'b0 || out_pending !== 3'b000) begin
            errors++;
            $display("FAIL wd_clear: stall=%b pend=%b exp 0 000", out_stall, out_pending);
        end
        cyc(3'b001, 3'b011, 1'b0);
        for (int k = 0; k < 4; k++) cyc(3'b000, 3'b011, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (out_stall !== 1'b0) begin
            errors++;
            $display("FAIL wd_reset_during: stall=%b exp=0", out_stall);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (out_stall !== 1'b0 || out_pending !== 3'b000) begin
            errors++;
            $display("FAIL wd_reset_after: stall=%b pend=%b exp 0 000", out_stall, out_pending);
        end
`else
        cyc(3'b001, 3'b011, 1'b0);
        for (int k = 0; k < 12; k++) begin
            cyc(3'b000, 3'b011, 1'b0);
            checks++;
            if (out_stall !== 1'b0) begin
                errors++;
                $display("FAIL stall_off_%0d: stall=%b exp=0", k, out_stall);
            end
        end
        cyc(3'b000, 3'b011, 1'b1);
        cyc(3'b000, 3'b011, 1'b0);
`endif
    endtask

    initial begin
        reset    = 1'b1;
        in_wait  = 3'b000;
        in_mask  = 3'b000;
        in_flush = 1'b0;
        test_reset;
        test_arrival;
        test_mask;
        test_overflow_back_to_back;
        test_flush;
        test_reset_gen_wrap;
        test_sat_cancel;
        test_watchdog;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
